cam_cfg_seq: RTL and testbench
==============================

CAM_CFG_SEQ -- requirements
Module: cam_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h3C: 7-bit sensor address in bits [6:0], passed unchanged to the I2C driver.
REQ-002 Parameter TBL_AW, default 8: table address width, so the table holds up to 256 entries.
REQ-003 Parameter MAX_RETRY, default 3: retries allowed per entry after a NACK.
REQ-004 Parameter GAP_CYC, default 16: idle clk_i cycles between consecutive transactions.
REQ-005 Parameter START_TO, default 64: cycles to wait for drv_busy to rise after drv_start_en.
REQ-006 Reset is rst_n, asynchronous, active-low; clock is clk_i.
REQ-007 clk_i  in  1  same clock as the I2C driver.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cfg_start  in  1  single-cycle pulse; starts a table walk from entry 0; ignored unless state is IDLE, DONE or FAIL.
REQ-010 tbl_addr  out  TBL_AW  table read address.
REQ-011 tbl_data  in  32  table entry, valid 1 cycle after tbl_addr changes (synchronous ROM).
REQ-012 drv_start_en  out  1  one-cycle start pulse to the driver.
REQ-013 drv_wr_rd_flag  out  1  tied to 0 (write only).
REQ-014 drv_dev_addr  out  8  equals DEV_ADDR.
REQ-015 drv_register  out  16  entry bits [23:8].
REQ-016 drv_data_byte  out  8  entry bits [7:0].
REQ-017 drv_busy, drv_err  in  1 each  driver status.
REQ-018 cfg_busy, cfg_done, cfg_fail  out  1 each  sequencer status.
REQ-019 fail_idx  out  TBL_AW  index of the failing entry.
REQ-020 wr_count  out  16  number of successful writes in the current walk.

Function
REQ-021 Entry format: [31:24] opcode. 8'h00 = WRITE. 8'h01 = DELAY, with [23:0] giving the delay in units of 256 cycles. 8'hFF = END. Any other opcode is treated as END.
REQ-022 State machine states: IDLE, FETCH, DECODE, ISSUE, WAIT_UP, WAIT_DN, GAP, DELAY, DONE, FAIL.
REQ-023 Transitions from IDLE, DONE and FAIL: on cfg_start, clear wr_count, fail_idx, cfg_done and cfg_fail; set tbl_addr to 0; go to FETCH.
REQ-024 FETCH: wait exactly 1 cycle, then go to DECODE.
REQ-025 DECODE dispatch: WRITE -> ISSUE; DELAY with a nonzero count -> DELAY; DELAY with count 0 -> next entry; END -> DONE.
REQ-026 Register and data outputs: drv_register and drv_data_byte are registered in DECODE and held stable until WAIT_DN exits.
REQ-027 ISSUE: assert drv_start_en for exactly 1 cycle, clear the sticky error flag, then go to WAIT_UP.
REQ-028 WAIT_UP: go to WAIT_DN when drv_busy=1. If START_TO cycles pass without drv_busy, treat the transaction as a failed attempt.
REQ-029 Sticky error capture: while in WAIT_DN, a sticky flag is set on any cycle with drv_err=1. The driver clears err before busy falls, so the sticky flag is the only valid NACK indication.
REQ-030 WAIT_DN exit: on drv_busy=0, a clear sticky flag means success (wr_count+1, retry counter cleared, go to GAP). A set sticky flag means a failed attempt.
REQ-031 Failed attempt: if the retry counter < MAX_RETRY, increment it and go to GAP, then reissue the same entry. Otherwise latch fail_idx = tbl_addr and go to FAIL.
REQ-032 GAP: wait GAP_CYC cycles. On success, advance to the next entry via FETCH; on retry, go back to ISSUE.
REQ-033 DELAY: count down count*256 cycles using a 32-bit counter, then advance to the next entry.
REQ-034 Advance rule: tbl_addr increments. When tbl_addr equals 2^TBL_AW-1, advancing goes to DONE with no wrap-around.
REQ-035 cfg_busy = 1 in every state except IDLE, DONE and FAIL.
REQ-036 cfg_done and cfg_fail are level outputs held until the next accepted cfg_start. They are mutually exclusive.
REQ-037 drv_start_en is never asserted while drv_busy=1 or while in any state other than ISSUE.
REQ-038 cfg_start received while cfg_busy=1 is ignored, with no effect on the state or counters.

Reset
REQ-039 Asynchronous reset state: IDLE; all outputs 0 except drv_dev_addr=DEV_ADDR; all counters and the sticky flag cleared.
REQ-040 Reset asserted mid-transaction returns to IDLE immediately; no drv_start_en is generated until a new cfg_start.

Structure
REQ-041 Shared package cam_cfg_pkg holds the opcode constants (OP_WRITE, OP_DELAY, OP_END), the state encoding and the entry field positions.
REQ-042 One sub-module, cam_cfg_rom: synchronous table ROM with 1-cycle latency, instantiated at top level beside cam_cfg_seq and the driver, not inside cam_cfg_seq.

Verification
REQ-043 Three-entry write walk: table {00_3008_82, 00_3103_03, FF_000000}, driver model busy 40 cycles, no err -> two drv_start_en pulses carrying register 16'h3008/data 8'h82 then 16'h3103/8'h03; then cfg_done=1, wr_count=2.
REQ-044 Delay entry: table {01_000004, 00_0100_01, FF} -> first drv_start_en appears no earlier than 1024 cycles after DECODE of entry 0.
REQ-045 NACK retry: entry 1 returns an err pulse in the middle of busy on its first 2 attempts -> 3 pulses for entry 1 in total; then cfg_done=1, wr_count=2 (for a 2-write table).
REQ-046 Persistent NACK: entry 1 always NACKs with MAX_RETRY=3 -> 4 attempts, then cfg_fail=1, fail_idx=1, cfg_done=0.
REQ-047 Start timeout: drv_busy held at 0 -> each attempt aborts after 64 cycles; cfg_fail=1 after 4 attempts.
REQ-048 Reset mid-walk: rst_n pulsed low during WAIT_DN -> all outputs at reset values, no drv_start_en; a later cfg_start restarts from entry 0.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared constants for the camera register-table sequencer:
// opcodes, entry field positions and FSM state encoding.
package cam_cfg_pkg;

   localparam logic [7:0] OP_WRITE = 8'h00;
   localparam logic [7:0] OP_DELAY = 8'h01;
   localparam logic [7:0] OP_END   = 8'hFF;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 24;
   localparam int REG_HI = 23;
   localparam int REG_LO = 8;
   localparam int DAT_HI = 7;
   localparam int DAT_LO = 0;
   localparam int CNT_HI = 23;
   localparam int CNT_LO = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_UP,
      S_WAIT_DN,
      S_GAP,
      S_DELAY,
      S_DONE,
      S_FAIL
   } state_t;

endpackage

// File: rtl/cam_cfg_rom.sv
// Synchronous configuration table ROM, one-cycle read latency.
// Holds a short default sensor init sequence; unused slots read END.
module cam_cfg_rom
   import cam_cfg_pkg::*;
#(
   parameter int TBL_AW = 8
) (
   input  logic              clk_i,
   input  logic [TBL_AW-1:0] addr,
   output logic [31:0]       data
);

   always_ff @(posedge clk_i) begin
      if (addr == TBL_AW'(0))
         data <= {OP_WRITE, 16'h3008, 8'h82};
      else if (addr == TBL_AW'(1))
         data <= {OP_WRITE, 16'h3103, 8'h03};
      else
         data <= {OP_END, 24'h000000};
   end

endmodule

// File: rtl/cam_cfg_seq.sv
// Walks a register table and issues I2C writes through the driver,
// with per-entry NACK retry, start timeout and programmable delays.
module cam_cfg_seq
   import cam_cfg_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR  = 8'h3C,
   parameter int         TBL_AW    = 8,
   parameter int         MAX_RETRY = 3,
   parameter int         GAP_CYC   = 16,
   parameter int         START_TO  = 64
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              cfg_start,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [31:0]       tbl_data,
   output logic              drv_start_en,
   output logic              drv_wr_rd_flag,
   output logic [7:0]        drv_dev_addr,
   output logic [15:0]       drv_register,
   output logic [7:0]        drv_data_byte,
   input  logic              drv_busy,
   input  logic              drv_err,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_fail,
   output logic [TBL_AW-1:0] fail_idx,
   output logic [15:0]       wr_count
);

   localparam logic [7:0]  RTY_MAX  = 8'(MAX_RETRY);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
   localparam logic [15:0] TO_LAST  = 16'(START_TO - 1);

   state_t      state, nxt;
   logic [15:0] reg_r;
   logic [7:0]  dat_r;
   logic [31:0] dly_cnt;
   logic [15:0] gap_cnt, to_cnt;
   logic [7:0]  retry;
   logic        rty_pend, sticky;
   logic        go, adv, att_ok, att_bad;

   logic [7:0]  opc;
   logic [23:0] cnt;
   logic        is_wr, is_dly, cnt_nz, last, can_retry;

   assign opc       = tbl_data[OPC_HI:OPC_LO];
   assign cnt       = tbl_data[CNT_HI:CNT_LO];
   assign is_wr     = (opc == OP_WRITE);
   assign is_dly    = (opc == OP_DELAY);
   assign cnt_nz    = (cnt != 24'd0);
   assign last      = (tbl_addr == '1);
   assign can_retry = (retry < RTY_MAX);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt     = state;
      go      = 1'b0;
      adv     = 1'b0;
      att_ok  = 1'b0;
      att_bad = 1'b0;
      unique case (state)
         S_IDLE, S_DONE, S_FAIL:
            if (cfg_start) begin
               go  = 1'b1;
               nxt = S_FETCH;
            end
         S_FETCH: nxt = S_DECODE;
         S_DECODE:
            unique case (1'b1)
               is_wr:            nxt = S_ISSUE;
               is_dly && cnt_nz: nxt = S_DELAY;
               is_dly && !cnt_nz: adv = 1'b1;
               default:          nxt = S_DONE;
            endcase
         S_ISSUE:
            if (!drv_busy) nxt = S_WAIT_UP;
         S_WAIT_UP:
            if (drv_busy)               nxt = S_WAIT_DN;
            else if (to_cnt == TO_LAST) att_bad = 1'b1;
         S_WAIT_DN:
            if (!drv_busy) begin
               att_ok  = !sticky;
               att_bad = sticky;
            end
         S_GAP:
            if (gap_cnt == GAP_LAST) begin
               if (rty_pend) nxt = S_ISSUE;
               else          adv = 1'b1;
            end
         S_DELAY:
            if (dly_cnt == 32'd1) adv = 1'b1;
         default: nxt = S_IDLE;
      endcase
      if (att_ok)  nxt = S_GAP;
      if (att_bad) nxt = can_retry ? S_GAP : S_FAIL;
      if (adv)     nxt = last ? S_DONE : S_FETCH;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         tbl_addr <= '0;
         fail_idx <= '0;
         wr_count <= '0;
         cfg_done <= 1'b0;
         cfg_fail <= 1'b0;
         reg_r    <= '0;
         dat_r    <= '0;
         dly_cnt  <= '0;
         gap_cnt  <= '0;
         to_cnt   <= '0;
         retry    <= '0;
         rty_pend <= 1'b0;
         sticky   <= 1'b0;
      end else begin
         if (go) begin
            tbl_addr <= '0;
            fail_idx <= '0;
            wr_count <= '0;
            cfg_done <= 1'b0;
            cfg_fail <= 1'b0;
            retry    <= '0;
            rty_pend <= 1'b0;
         end
         if (state == S_DECODE && is_wr) begin
            reg_r <= tbl_data[REG_HI:REG_LO];
            dat_r <= tbl_data[DAT_HI:DAT_LO];
         end
         if (state == S_DECODE && is_dly)
            dly_cnt <= {cnt, 8'h00};
         else if (state == S_DELAY)
            dly_cnt <= dly_cnt - 32'd1;
         if (state == S_ISSUE) begin
            sticky <= 1'b0;
            to_cnt <= '0;
         end else if (state == S_WAIT_UP) begin
            to_cnt <= to_cnt + 16'd1;
         end
         if (state == S_WAIT_DN && drv_err) sticky <= 1'b1;
         if (state == S_GAP) gap_cnt <= gap_cnt + 16'd1;
         if (att_ok) begin
            wr_count <= wr_count + 16'd1;
            retry    <= '0;
            rty_pend <= 1'b0;
            gap_cnt  <= '0;
         end
         if (att_bad) begin
            if (can_retry) begin
               retry    <= retry + 8'd1;
               rty_pend <= 1'b1;
               gap_cnt  <= '0;
            end else begin
               fail_idx <= tbl_addr;
            end
         end
         // last entry finishes the walk rather than wrapping to 0
         if (adv && !last) tbl_addr <= tbl_addr + 1'b1;
         if (nxt == S_DONE && state != S_DONE) cfg_done <= 1'b1;
         if (nxt == S_FAIL && state != S_FAIL) cfg_fail <= 1'b1;
      end
   end

   assign drv_start_en   = (state == S_ISSUE) && !drv_busy;
   assign drv_wr_rd_flag = 1'b0;
   assign drv_dev_addr   = DEV_ADDR;
   assign drv_register   = reg_r;
   assign drv_data_byte  = dat_r;
   assign cfg_busy       = !(state == S_IDLE || state == S_DONE ||
                             state == S_FAIL);

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Scoreboard bench for cam_cfg_seq with a behavioural I2C driver
// and a switchable table source (ROM instance or bench table).
module tb_cam_cfg_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [7:0]  tbl_addr;
   logic [31:0] tbl_data, rom_data, model_q;
   logic        drv_start_en, drv_wr_rd_flag;
   logic [7:0]  drv_dev_addr, drv_data_byte;
   logic [15:0] drv_register;
   logic        drv_busy = 1'b0, drv_err = 1'b0;
   logic        cfg_busy, cfg_done, cfg_fail;
   logic [7:0]  fail_idx;
   logic [15:0] wr_count;

   logic [31:0] tbl [0:255];
   logic        use_rom = 1'b0;
   logic        drv_mute = 1'b0;
   logic [15:0] nack_reg = 16'h0000;
   int          nack_left = 0;
   int          n_tests = 0, n_fail = 0;
   int          cyc = 0, pulse_cnt = 0, first_cyc = 0;
   logic [23:0] exp_q [$];

   localparam int BUSY_CYC = 40;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) model_q <= tbl[tbl_addr];
   assign tbl_data = use_rom ? rom_data : model_q;

   cam_cfg_rom #(.TBL_AW(8)) u_rom (
      .clk_i(clk), .addr(tbl_addr), .data(rom_data)
   );

   cam_cfg_seq dut (
      .clk_i(clk), .rst_n(rst_n), .cfg_start(cfg_start),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .drv_start_en(drv_start_en), .drv_wr_rd_flag(drv_wr_rd_flag),
      .drv_dev_addr(drv_dev_addr), .drv_register(drv_register),
      .drv_data_byte(drv_data_byte), .drv_busy(drv_busy),
      .drv_err(drv_err), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .cfg_fail(cfg_fail), .fail_idx(fail_idx), .wr_count(wr_count)
   );

   // driver model + scoreboard pop on every start pulse
   initial begin
      logic [23:0] e;
      logic nack_now;
      forever begin
         @(negedge clk);
         if (drv_start_en === 1'b1) begin
            pulse_cnt++;
            if (pulse_cnt == 1) first_cyc = cyc;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL start_unexpected got reg=%h data=%h expected none",
                        drv_register, drv_data_byte);
            end else begin
               e = exp_q.pop_front();
               if ({drv_register, drv_data_byte} !== e) begin
                  n_fail++;
                  $display("FAIL start_payload got %h expected %h",
                           {drv_register, drv_data_byte}, e);
               end
            end
            nack_now = (drv_register == nack_reg) && (nack_left > 0);
            if (nack_now) nack_left--;
            if (!drv_mute) begin
               @(posedge clk); #1 drv_busy = 1'b1;
               for (int i = 0; i < BUSY_CYC; i++) begin
                  @(posedge clk); #1;
                  drv_err = (i == BUSY_CYC / 2) ? nack_now : 1'b0;
               end
               drv_busy = 1'b0;
               drv_err  = 1'b0;
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(cfg_done || cfg_fail) && n < budget) begin
         @(negedge clk); n++;
      end
      if (!(cfg_done || cfg_fail)) begin
         n_tests++; n_fail++;
         $display("FAIL wait_end got no done/fail expected one within %0d", budget);
      end
      @(negedge clk);
   endtask

   task automatic setup(input logic rom);
      use_rom = rom;
      drv_mute = 1'b0;
      nack_left = 0;
      pulse_cnt = 0;
      exp_q.delete();
      for (int i = 0; i < 256; i++) tbl[i] = 32'hFF00_0000;
      tbl[0] = 32'h0030_0882;
      tbl[1] = 32'h0031_0303;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if ({tbl_addr, drv_start_en, drv_wr_rd_flag, drv_register,
           drv_data_byte, cfg_busy, cfg_done, cfg_fail, fail_idx,
           wr_count} !== 61'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got nonzero expected all zero");
      end
      n_tests++;
      if (drv_dev_addr !== 8'h3C) begin
         n_fail++;
         $display("FAIL reset_dev_addr got %h expected 3c", drv_dev_addr);
      end
   endtask

   task automatic test_write_walk();
      int n = 0;
      setup(1'b1);
      exp_q.push_back(24'h3008_82);
      exp_q.push_back(24'h3103_03);
      pulse_start();
      while (pulse_cnt == 0 && n < 200) begin @(negedge clk); n++; end
      pulse_start();
      wait_end(5000);
      n_tests++;
      if ({cfg_done, cfg_fail, cfg_busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL walk_status got %b expected 100", {cfg_done, cfg_fail, cfg_busy});
      end
      n_tests++;
      if (wr_count !== 16'd2) begin
         n_fail++;
         $display("FAIL walk_wr_count got %0d expected 2", wr_count);
      end
      n_tests++;
      if (exp_q.size() !== 0 || pulse_cnt !== 2) begin
         n_fail++;
         $display("FAIL walk_pulses got %0d expected 2", pulse_cnt);
      end
   endtask

   task automatic test_delay();
      int c0;
      setup(1'b0);
      tbl[0] = 32'h0100_0004;
      tbl[1] = 32'h0001_0001;
      exp_q.push_back(24'h0100_01);
      pulse_start();
      c0 = cyc;
      wait_end(5000);
      n_tests++;
      if (first_cyc - c0 < 1025) begin
         n_fail++;
         $display("FAIL delay_latency got %0d expected >=1025", first_cyc - c0);
      end
      n_tests++;
      if ({cfg_done, wr_count} !== {1'b1, 16'd1}) begin
         n_fail++;
         $display("FAIL delay_done got done=%b cnt=%0d expected done=1 cnt=1",
                  cfg_done, wr_count);
      end
   endtask

   task automatic test_nack_retry();
      setup(1'b0);
      nack_reg = 16'h3103;
      nack_left = 2;
      exp_q.push_back(24'h3008_82);
      repeat (3) exp_q.push_back(24'h3103_03);
      pulse_start();
      wait_end(5000);
      n_tests++;
      if ({cfg_done, cfg_fail, wr_count} !== {2'b10, 16'd2}) begin
         n_fail++;
         $display("FAIL retry_status got done=%b fail=%b cnt=%0d expected 1 0 2",
                  cfg_done, cfg_fail, wr_count);
      end
      n_tests++;
      if (pulse_cnt !== 4) begin
         n_fail++;
         $display("FAIL retry_pulses got %0d expected 4", pulse_cnt);
      end
   endtask

   task automatic test_nack_persist();
      setup(1'b0);
      nack_reg = 16'h3103;
      nack_left = 1000;
      exp_q.push_back(24'h3008_82);
      repeat (4) exp_q.push_back(24'h3103_03);
      pulse_start();
      wait_end(5000);
      n_tests++;
      if ({cfg_done, cfg_fail, fail_idx} !== {2'b01, 8'd1}) begin
         n_fail++;
         $display("FAIL persist_status got done=%b fail=%b idx=%0d expected 0 1 1",
                  cfg_done, cfg_fail, fail_idx);
      end
      n_tests++;
      if (pulse_cnt !== 5 || wr_count !== 16'd1) begin
         n_fail++;
         $display("FAIL persist_counts got pulses=%0d cnt=%0d expected 5 1",
                  pulse_cnt, wr_count);
      end
   endtask

   task automatic test_start_timeout();
      int c0;
      setup(1'b0);
      drv_mute = 1'b1;
      repeat (4) exp_q.push_back(24'h3008_82);
      pulse_start();
      c0 = cyc;
      wait_end(5000);
      n_tests++;
      if ({cfg_done, cfg_fail, fail_idx} !== {2'b01, 8'd0}) begin
         n_fail++;
         $display("FAIL timeout_status got done=%b fail=%b idx=%0d expected 0 1 0",
                  cfg_done, cfg_fail, fail_idx);
      end
      n_tests++;
      if (pulse_cnt !== 4 || (cyc - c0) < 4 * 64) begin
         n_fail++;
         $display("FAIL timeout_attempts got pulses=%0d cycles=%0d expected 4 >=256",
                  pulse_cnt, cyc - c0);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      setup(1'b0);
      exp_q.push_back(24'h3008_82);
      pulse_start();
      while (!(drv_busy && cfg_busy) && n < 500) begin @(negedge clk); n++; end
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({tbl_addr, drv_start_en, drv_register, drv_data_byte, cfg_busy,
           cfg_done, cfg_fail, fail_idx, wr_count, drv_dev_addr} !==
          {60'd0, 8'h3C}) begin
         n_fail++;
         $display("FAIL midreset_outputs got busy=%b reg=%h expected all reset values",
                  cfg_busy, drv_register);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (60) @(negedge clk);
      n_tests++;
      if (pulse_cnt !== 1 || cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_quiet got pulses=%0d busy=%b expected 1 0",
                  pulse_cnt, cfg_busy);
      end
      exp_q.push_back(24'h3008_82);
      exp_q.push_back(24'h3103_03);
      pulse_start();
      wait_end(5000);
      n_tests++;
      if ({cfg_done, wr_count, pulse_cnt} !== {1'b1, 16'd2, 32'd3}) begin
         n_fail++;
         $display("FAIL midreset_restart got done=%b cnt=%0d pulses=%0d expected 1 2 3",
                  cfg_done, wr_count, pulse_cnt);
      end
   endtask

   task automatic test_addr_end();
      setup(1'b0);
      for (int i = 0; i < 256; i++) tbl[i] = 32'h0100_0000;
      pulse_start();
      wait_end(5000);
      n_tests++;
      if ({cfg_done, cfg_fail, tbl_addr, wr_count} !== {2'b10, 8'hFF, 16'd0}) begin
         n_fail++;
         $display("FAIL addr_end got done=%b fail=%b addr=%h cnt=%0d expected 1 0 ff 0",
                  cfg_done, cfg_fail, tbl_addr, wr_count);
      end
      n_tests++;
      if (pulse_cnt !== 0) begin
         n_fail++;
         $display("FAIL addr_end_pulses got %0d expected 0", pulse_cnt);
      end
   endtask

   initial begin
      setup(1'b0);
      repeat (3) @(posedge clk);
      test_reset();
      #1 rst_n = 1'b1;
      test_write_walk();
      test_delay();
      test_nack_retry();
      test_nack_persist();
      test_start_timeout();
      test_reset_mid();
      test_addr_end();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
